// File: rtl/pc_stage.sv
// -----------------------------------------------------------------------------
// pc_stage
//   Program-counter stage of the MIPS fetch path. Registers the next PC chosen
//   by the upstream 2:1 PC-select mux and presents it to instruction memory
//   with a valid/ready handshake. The stage holds the PC during decode stalls,
//   remembers redirects that arrive while a fetch is blocked, traps misaligned
//   targets and counts accepted fetches.
//
// Ports
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous active-high reset
//   next_pc      in   32     next PC from the upstream mux
//   redirect     in   1      1 = next_pc is a branch/jump target (mux ctrl)
//   stall        in   1      hazard stall from decode; hold the PC
//   imem_ready   in   1      instruction memory accepts the current pc
//   pc           out  32     current fetch address
//   pc_plus4     out  32     pc + 4, fed back to mux in1
//   fetch_valid  out  1      pc is a valid fetch request
//   flush        out  1      one-cycle pulse after a redirect target is loaded
//   misalign_err out  1      sticky: last selected target was misaligned
//   fetch_count  out  CNT_W  number of accepted fetches, wraps
// -----------------------------------------------------------------------------
module pc_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      next_pc,
  input  logic             redirect,
  input  logic             stall,
  input  logic             imem_ready,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             fetch_valid,
  output logic             flush,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      redir_tgt_q, redir_tgt_d;
  logic             redir_pend_q, redir_pend_d;
  logic             flush_q, flush_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             accept;
  logic             sel_is_redir;
  logic [31:0]      sel_tgt;

  // A request is outstanding in RUN and WAIT; BOOT and ERR never request.
  assign fetch_valid = (state_q == RUN) || (state_q == WAIT);
  assign accept      = fetch_valid & imem_ready & ~stall;

  // A redirect arriving on the accepting cycle is newer than any pending
  // target, so it wins; otherwise a pending target overrides the mux output.
  assign sel_is_redir = redirect | redir_pend_q;
  assign sel_tgt      = redirect     ? next_pc     :
                        redir_pend_q ? redir_tgt_q : next_pc;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    redir_tgt_d  = redir_tgt_q;
    redir_pend_d = redir_pend_q;
    flush_d      = 1'b0;
    misalign_d   = misalign_q;
    count_d      = count_q;

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        if (redirect) begin
          redir_pend_d = 1'b1;
          redir_tgt_d  = next_pc;
        end
      end

      RUN, WAIT: begin
        if (accept) begin
          redir_pend_d = 1'b0;
          state_d      = RUN;
          if (sel_tgt[1:0] != 2'b00) begin
            // Misaligned target: keep the old pc and trap; not counted.
            state_d    = ERR;
            misalign_d = 1'b1;
          end else begin
            pc_d    = sel_tgt;
            count_d = count_q + CNT_W'(1);
            flush_d = sel_is_redir;
          end
        end else begin
          // Blocked cycle: remember the redirect, last one wins.
          if (redirect) begin
            redir_pend_d = 1'b1;
            redir_tgt_d  = next_pc;
          end
          if (state_q == RUN && !imem_ready && !stall) begin
            state_d = WAIT;
          end else if (state_q == WAIT && imem_ready) begin
            // Memory is ready but decode stalls: back to RUN, pc still held.
            state_d = RUN;
          end
        end
      end

      ERR: begin
        redir_pend_d = 1'b0;
        if (redirect && next_pc[1:0] == 2'b00) begin
          state_d    = RUN;
          pc_d       = next_pc;
          misalign_d = 1'b0;
          flush_d    = 1'b1;
        end
      end

      default: state_d = BOOT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      redir_tgt_q  <= '0;
      redir_pend_q <= 1'b0;
      flush_q      <= 1'b0;
      misalign_q   <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_tgt_q  <= redir_tgt_d;
      redir_pend_q <= redir_pend_d;
      flush_q      <= flush_d;
      misalign_q   <= misalign_d;
      count_q      <= count_d;
    end
  end

  assign pc           = pc_q;
  assign pc_plus4     = pc_q + 32'd4;
  assign flush        = flush_q;
  assign misalign_err = misalign_q;
  assign fetch_count  = count_q;

endmodule

// File: tb/tb_pc_stage.sv
// -----------------------------------------------------------------------------
// tb_pc_stage
//   Self-checking bench for pc_stage: a directed vector table from reset, a
//   hand-written wrap / asynchronous-reset sequence, then randomized traffic
//   compared against a behavioural model of the fetch rules.
// -----------------------------------------------------------------------------
module tb_pc_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc;
  logic        redirect, stall, imem_ready;
  logic [31:0] pc, pc_plus4;
  logic        fetch_valid, flush, misalign_err;
  logic [31:0] fetch_count;

  int n_check = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  pc_stage #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .next_pc      (next_pc),
    .redirect     (redirect),
    .stall        (stall),
    .imem_ready   (imem_ready),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .fetch_valid  (fetch_valid),
    .flush        (flush),
    .misalign_err (misalign_err),
    .fetch_count  (fetch_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_check++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic s, input logic r, input logic rd, input logic [31:0] np);
    stall = s; imem_ready = r; redirect = rd; next_pc = np;
  endtask

  typedef struct {
    logic        stall, ready, redir;
    logic [31:0] npc;
    logic [31:0] pc;
    logic        fv, fl, err;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(logic s, logic r, logic rd, logic [31:0] np,
                              logic [31:0] p, logic fv, logic fl, logic e, logic [31:0] c);
    vec_t v;
    v.stall = s; v.ready = r; v.redir = rd; v.npc = np;
    v.pc = p; v.fv = fv; v.fl = fl; v.err = e; v.cnt = c;
    return v;
  endfunction

  // Behavioural model: a fetcher that is booting, fetching or trapped.
  // Memory wait is just "fetching without acceptance", so it needs no mode.
  int          m_mode;  // 0 boot, 1 fetching, 2 trapped
  logic [31:0] m_pc, m_tgt, m_cnt;
  logic        m_pend, m_flush, m_err;

  task automatic model_reset();
    m_mode = 0; m_pc = 32'h0; m_tgt = 32'h0; m_cnt = 32'h0;
    m_pend = 1'b0; m_flush = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic r, input logic rd, input logic [31:0] np);
    logic [31:0] t;
    logic        from_redir;
    m_flush = 1'b0;
    if (m_mode == 0) begin
      m_mode = 1;
      if (rd) begin m_pend = 1'b1; m_tgt = np; end
    end else if (m_mode == 1) begin
      if (r && !s) begin
        t = rd ? np : (m_pend ? m_tgt : np);
        from_redir = rd || m_pend;
        m_pend = 1'b0;
        if (t % 4 != 0) begin
          m_mode = 2; m_err = 1'b1;
        end else begin
          m_pc = t; m_cnt = m_cnt + 1; m_flush = from_redir;
        end
      end else if (rd) begin
        m_pend = 1'b1; m_tgt = np;
      end
    end else begin
      m_pend = 1'b0;
      if (rd && np % 4 == 0) begin
        m_mode = 1; m_pc = np; m_err = 1'b0; m_flush = 1'b1;
      end
    end
  endtask

  initial begin
    logic [31:0] rnd, np;
    logic        rs, rr, rrd;

    vecs[0]  = mk(0,1,0,32'h004, 32'h000,1,0,0, 0);   // BOOT -> RUN, pc stays
    vecs[1]  = mk(0,1,0,32'h004, 32'h004,1,0,0, 1);
    vecs[2]  = mk(0,1,0,32'h008, 32'h008,1,0,0, 2);
    vecs[3]  = mk(0,1,0,32'h00C, 32'h00C,1,0,0, 3);
    vecs[4]  = mk(0,1,0,32'h010, 32'h010,1,0,0, 4);
    vecs[5]  = mk(1,1,0,32'h014, 32'h010,1,0,0, 4);   // stall holds
    vecs[6]  = mk(1,1,0,32'h014, 32'h010,1,0,0, 4);
    vecs[7]  = mk(0,1,0,32'h014, 32'h014,1,0,0, 5);
    vecs[8]  = mk(0,1,0,32'h018, 32'h018,1,0,0, 6);
    vecs[9]  = mk(0,1,1,32'h020, 32'h020,1,1,0, 7);
    vecs[10] = mk(0,1,1,32'h400, 32'h400,1,1,0, 8);   // direct redirect
    vecs[11] = mk(0,1,0,32'h404, 32'h404,1,0,0, 9);   // flush drops
    vecs[12] = mk(0,0,1,32'h800, 32'h404,1,0,0, 9);   // WAIT, redirect pending
    vecs[13] = mk(0,0,0,32'h408, 32'h404,1,0,0, 9);
    vecs[14] = mk(0,1,0,32'h408, 32'h800,1,1,0,10);   // pending overrides
    vecs[15] = mk(0,1,0,32'h804, 32'h804,1,0,0,11);
    vecs[16] = mk(0,1,1,32'h402, 32'h804,0,0,1,11);   // misaligned -> ERR
    vecs[17] = mk(0,1,0,32'h808, 32'h804,0,0,1,11);
    vecs[18] = mk(0,1,1,32'h500, 32'h500,1,1,0,11);   // recover from ERR
    vecs[19] = mk(0,1,0,32'h504, 32'h504,1,0,0,12);
    vecs[20] = mk(1,1,1,32'h900, 32'h504,1,0,0,12);   // stall beats redirect
    vecs[21] = mk(1,1,1,32'hA00, 32'h504,1,0,0,12);   // last redirect wins
    vecs[22] = mk(0,1,0,32'h508, 32'hA00,1,1,0,13);
    vecs[23] = mk(0,1,0,32'hA04, 32'hA04,1,0,0,14);

    rst = 1'b1;
    drive(0, 1, 0, 32'h4);
    repeat (3) @(posedge clk);
    #1;
    check("reset pc",       pc,           32'h0);
    check("reset pc_plus4", pc_plus4,     32'h4);
    check("reset valid",    fetch_valid,  1'b0);
    check("reset flush",    flush,        1'b0);
    check("reset err",      misalign_err, 1'b0);
    check("reset count",    fetch_count,  32'h0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].stall, vecs[i].ready, vecs[i].redir, vecs[i].npc);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d pc", i),       pc,           vecs[i].pc);
      check($sformatf("vec%0d pc_plus4", i), pc_plus4,     vecs[i].pc + 32'd4);
      check($sformatf("vec%0d valid", i),    fetch_valid,  vecs[i].fv);
      check($sformatf("vec%0d flush", i),    flush,        vecs[i].fl);
      check($sformatf("vec%0d err", i),      misalign_err, vecs[i].err);
      check($sformatf("vec%0d count", i),    fetch_count,  vecs[i].cnt);
      @(negedge clk);
    end

    // Address wrap at the top of memory, then async reset from WAIT.
    drive(0, 1, 1, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    check("wrap pc",       pc,       32'hFFFF_FFFC);
    check("wrap pc_plus4", pc_plus4, 32'h0);
    @(negedge clk);
    drive(0, 1, 0, 32'h0);
    @(posedge clk); #1;
    check("wrap advance", pc,          32'h0);
    check("wrap count",   fetch_count, 32'd16);
    @(negedge clk);
    drive(0, 1, 0, 32'h4);
    @(posedge clk); #1;
    check("post wrap pc", pc, 32'h4);
    @(negedge clk);
    drive(0, 0, 0, 32'h8);
    @(posedge clk); #1;
    check("wait pc",    pc,          32'h4);
    check("wait valid", fetch_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async rst pc",    pc,          32'h0);
    check("async rst valid", fetch_valid, 1'b0);
    check("async rst count", fetch_count, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the model.
    model_reset();
    for (int i = 0; i < 600; i++) begin
      rnd = $urandom;
      rs  = ($urandom_range(0, 4) == 0);
      rr  = ($urandom_range(0, 3) != 0);
      rrd = ($urandom_range(0, 4) == 0);
      if (rrd) begin
        np = {rnd[31:2], 2'b00};
        if ($urandom_range(0, 7) == 0) np[1:0] = 2'($urandom_range(1, 3));
      end else begin
        np = m_pc + 32'd4;
      end
      drive(rs, rr, rrd, np);
      @(posedge clk);
      model_step(rs, rr, rrd, np);
      #1;
      check("rand pc",       pc,           m_pc);
      check("rand pc_plus4", pc_plus4,     m_pc + 32'd4);
      check("rand valid",    fetch_valid,  (m_mode == 1));
      check("rand flush",    flush,        m_flush);
      check("rand err",      misalign_err, m_err);
      check("rand count",    fetch_count,  m_cnt);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
